tree_resource_credit_sched: RTL and testbench

//  Shares one pipelined resource (e.g. a multiplier core) between NUM_IN packet requesters.

---
 rtl/tree_resource_credit_sched.sv | 168 ++++++++++++++++
 tb/tb_tree_resource_credit_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_resource_credit_sched.sv
// Round-robin packet arbiter sharing one pipelined core between NUM_IN requesters, with per-requester
// outstanding-packet credit; responses are steered back by the requester tag stamped into ctl.
module tree_resource_credit_sched #(
  parameter int NUM_IN      = 4,
  parameter int CTL_BITS    = 16,
  parameter int DAT_BITS    = 64,
  parameter int OVR_WRT_BIT = 0,
  parameter int MAX_OUT     = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [NUM_IN-1:0]                      i_req_val,
  input  logic [NUM_IN-1:0]                      i_req_sop,
  input  logic [NUM_IN-1:0]                      i_req_eop,
  input  logic [NUM_IN*DAT_BITS-1:0]             i_req_dat,
  input  logic [NUM_IN*CTL_BITS-1:0]             i_req_ctl,
  output logic [NUM_IN-1:0]                      o_req_rdy,
  output logic                                   o_res_val,
  output logic                                   o_res_sop,
  output logic                                   o_res_eop,
  output logic [DAT_BITS-1:0]                    o_res_dat,
  output logic [CTL_BITS-1:0]                    o_res_ctl,
  input  logic                                   i_res_rdy,
  input  logic                                   i_rsp_val,
  input  logic                                   i_rsp_sop,
  input  logic                                   i_rsp_eop,
  input  logic [DAT_BITS-1:0]                    i_rsp_dat,
  input  logic [CTL_BITS-1:0]                    i_rsp_ctl,
  output logic                                   o_rsp_rdy,
  output logic [NUM_IN-1:0]                      o_rsp_val,
  output logic                                   o_rsp_sop,
  output logic                                   o_rsp_eop,
  output logic [DAT_BITS-1:0]                    o_rsp_dat,
  output logic [CTL_BITS-1:0]                    o_rsp_ctl,
  input  logic [NUM_IN-1:0]                      i_rsp_rdy,
  output logic [NUM_IN*$clog2(MAX_OUT+1)-1:0]    o_out_cnt,
  output logic                                   o_err
);

  localparam int TW = $clog2(NUM_IN);
  localparam int CW = $clog2(MAX_OUT+1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       grant_q, grant_d;
  logic [TW-1:0]       rr_q, rr_d;
  logic [CW-1:0]       cnt_q [NUM_IN];
  logic [CW-1:0]       cnt_d [NUM_IN];
  logic                err_q, err_d;

  logic [NUM_IN-1:0]   elig;
  logic [NUM_IN-1:0]   inc_v, dec_v;
  logic                found, issue_eop, tag_ok, rsp_eop;
  logic [TW-1:0]       rsp_tag;
  logic [CTL_BITS-1:0] ctl_tmp;
  int                  idx;

  // Request side: arbitration in IDLE, packet forwarding in BUSY
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    o_req_rdy = '0;
    o_res_val = 1'b0;
    o_res_sop = 1'b0;
    o_res_eop = 1'b0;
    o_res_dat = '0;
    ctl_tmp   = '0;
    o_res_ctl = '0;
    issue_eop = 1'b0;
    found     = 1'b0;
    idx       = 0;
    elig      = '0;
    for (int i = 0; i < NUM_IN; i++)
      elig[i] = i_req_val[i] & i_req_sop[i] & (cnt_q[i] < CW'(MAX_OUT));
    if (state_q == IDLE) begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
          if (!found && i == idx && elig[i]) begin
            found   = 1'b1;
            grant_d = TW'(i);
          end
        end
      end
      if (found) state_d = BUSY;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant_q == TW'(i)) begin
          o_res_val    = i_req_val[i];
          o_res_sop    = i_req_sop[i];
          o_res_eop    = i_req_eop[i];
          o_res_dat    = i_req_dat[i*DAT_BITS +: DAT_BITS];
          ctl_tmp      = i_req_ctl[i*CTL_BITS +: CTL_BITS];
          o_req_rdy[i] = i_res_rdy;
        end
      end
      ctl_tmp[OVR_WRT_BIT +: TW] = grant_q;
      o_res_ctl = ctl_tmp;
      issue_eop = o_res_val & i_res_rdy & o_res_eop;
      if (issue_eop) begin
        state_d = IDLE;
        rr_d    = (grant_q == TW'(NUM_IN-1)) ? '0 : grant_q + TW'(1);
      end
    end
  end

  // Response side: steer by tag; unknown tags are swallowed so the core never stalls on them
  always_comb begin
    rsp_tag   = i_rsp_ctl[OVR_WRT_BIT +: TW];
    o_rsp_val = '0;
    o_rsp_rdy = 1'b1;
    tag_ok    = 1'b0;
    o_rsp_sop = i_rsp_sop;
    o_rsp_eop = i_rsp_eop;
    o_rsp_dat = i_rsp_dat;
    o_rsp_ctl = i_rsp_ctl;
    for (int i = 0; i < NUM_IN; i++) begin
      if (rsp_tag == TW'(i)) begin
        tag_ok       = 1'b1;
        o_rsp_val[i] = i_rsp_val;
        o_rsp_rdy    = i_rsp_rdy[i];
      end
    end
    rsp_eop = i_rsp_val & o_rsp_rdy & i_rsp_eop & tag_ok;
  end

  // Outstanding counters; a simultaneous issue and return cancel out
  always_comb begin
    err_d     = err_q;
    o_out_cnt = '0;
    inc_v     = '0;
    dec_v     = '0;
    if (i_rsp_val && !tag_ok) err_d = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      inc_v[i] = issue_eop & (grant_q == TW'(i));
      dec_v[i] = rsp_eop & (rsp_tag == TW'(i));
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CW'(1);
      end
      o_out_cnt[i*CW +: CW] = cnt_q[i];
    end
    o_err = err_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_tree_resource_credit_sched.sv
// Directed bench: a 4-requester instance for arbitration/credit/reset, a 3-requester instance for bad tags.
module tb_tree_resource_credit_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // 4-requester instance
  logic         rst_n;
  logic [3:0]   req_val, req_sop, req_eop, req_rdy;
  logic [255:0] req_dat;
  logic [63:0]  req_ctl;
  logic         res_val, res_sop, res_eop, res_rdy;
  logic [63:0]  res_dat;
  logic [15:0]  res_ctl;
  logic         rin_val, rin_sop, rin_eop, rin_rdy;
  logic [63:0]  rin_dat;
  logic [15:0]  rin_ctl;
  logic [3:0]   rsp_val, rsp_rdy;
  logic         rsp_sop, rsp_eop;
  logic [63:0]  rsp_dat;
  logic [15:0]  rsp_ctl;
  logic [11:0]  out_cnt;
  logic         err;

  tree_resource_credit_sched #(.NUM_IN(4), .CTL_BITS(16), .DAT_BITS(64), .OVR_WRT_BIT(0), .MAX_OUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_val(req_val), .i_req_sop(req_sop), .i_req_eop(req_eop),
    .i_req_dat(req_dat), .i_req_ctl(req_ctl), .o_req_rdy(req_rdy),
    .o_res_val(res_val), .o_res_sop(res_sop), .o_res_eop(res_eop),
    .o_res_dat(res_dat), .o_res_ctl(res_ctl), .i_res_rdy(res_rdy),
    .i_rsp_val(rin_val), .i_rsp_sop(rin_sop), .i_rsp_eop(rin_eop),
    .i_rsp_dat(rin_dat), .i_rsp_ctl(rin_ctl), .o_rsp_rdy(rin_rdy),
    .o_rsp_val(rsp_val), .o_rsp_sop(rsp_sop), .o_rsp_eop(rsp_eop),
    .o_rsp_dat(rsp_dat), .o_rsp_ctl(rsp_ctl), .i_rsp_rdy(rsp_rdy),
    .o_out_cnt(out_cnt), .o_err(err)
  );

  // 3-requester instance, tag at ctl[5:4]
  logic         rst3_n;
  logic [2:0]   req_val3, req_rdy3;
  logic [23:0]  req_dat3, req_ctl3;
  logic         res_val3, res_sop3, res_eop3;
  logic [7:0]   res_dat3, res_ctl3;
  logic         rin_val3, rin_eop3, rin_rdy3;
  logic [7:0]   rin_dat3, rin_ctl3;
  logic [2:0]   rsp_val3, rsp_rdy3;
  logic         rsp_sop3, rsp_eop3;
  logic [7:0]   rsp_dat3, rsp_ctl3;
  logic [5:0]   out_cnt3;
  logic         err3;

  tree_resource_credit_sched #(.NUM_IN(3), .CTL_BITS(8), .DAT_BITS(8), .OVR_WRT_BIT(4), .MAX_OUT(2)) dut3 (
    .i_clk(clk), .i_rst_n(rst3_n),
    .i_req_val(req_val3), .i_req_sop(req_val3), .i_req_eop(req_val3),
    .i_req_dat(req_dat3), .i_req_ctl(req_ctl3), .o_req_rdy(req_rdy3),
    .o_res_val(res_val3), .o_res_sop(res_sop3), .o_res_eop(res_eop3),
    .o_res_dat(res_dat3), .o_res_ctl(res_ctl3), .i_res_rdy(1'b1),
    .i_rsp_val(rin_val3), .i_rsp_sop(rin_eop3), .i_rsp_eop(rin_eop3),
    .i_rsp_dat(rin_dat3), .i_rsp_ctl(rin_ctl3), .o_rsp_rdy(rin_rdy3),
    .o_rsp_val(rsp_val3), .o_rsp_sop(rsp_sop3), .o_rsp_eop(rsp_eop3),
    .o_rsp_dat(rsp_dat3), .o_rsp_ctl(rsp_ctl3), .i_rsp_rdy(rsp_rdy3),
    .o_out_cnt(out_cnt3), .o_err(err3)
  );

  int pkt;

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    req_val = '0; req_sop = '0; req_eop = '0; req_dat = '0; req_ctl = '0; res_rdy = 1'b1;
    rin_val = 1'b0; rin_sop = 1'b0; rin_eop = 1'b0; rin_dat = '0; rin_ctl = '0; rsp_rdy = 4'hF;
    req_val3 = '0; req_dat3 = '0; req_ctl3 = '0;
    rin_val3 = 1'b0; rin_eop3 = 1'b0; rin_dat3 = '0; rin_ctl3 = '0; rsp_rdy3 = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy), 64'h0);
    chk("rst_res_val", 64'(res_val), 64'h0);
    chk("rst_out_cnt", 64'(out_cnt), 64'h0);
    chk("rst_err",     64'(err),     64'h0);
    cyc();
    rst_n = 1'b1;

    // 1: req0 three-beat packet, tag overwritten to 0
    req_val[0] = 1'b1; req_sop[0] = 1'b1; req_eop[0] = 1'b0;
    req_dat[63:0] = 64'hA0; req_ctl[15:0] = 16'hABC3;
    @(negedge clk);
    chk("t1_grant_cycle_idle", 64'(res_val), 64'h0);
    cyc();
    @(negedge clk);
    chk("t1_b0_val", 64'(res_val), 64'h1);
    chk("t1_b0_sop", 64'(res_sop), 64'h1);
    chk("t1_b0_rdy", 64'(req_rdy), 64'h1);
    chk("t1_b0_ctl", 64'(res_ctl), 64'hABC0);
    chk("t1_b0_dat", res_dat, 64'hA0);
    cyc();
    req_sop[0] = 1'b0; req_dat[63:0] = 64'hA1;
    @(negedge clk);
    chk("t1_b1_dat", res_dat, 64'hA1);
    cyc();
    req_eop[0] = 1'b1; req_dat[63:0] = 64'hA2;
    @(negedge clk);
    chk("t1_b2_eop", 64'(res_eop), 64'h1);
    cyc();
    req_val = '0; req_sop = '0; req_eop = '0;
    @(negedge clk);
    chk("t1_cnt0", 64'(out_cnt), 64'h1);
    chk("t1_idle", 64'(res_val), 64'h0);
    cyc();

    // 2: all four stream one-beat packets from reset, no responses
    rst_n = 1'b0;
    #1;
    chk("t2_rst_cnt", 64'(out_cnt), 64'h0);
    req_val = 4'hF; req_sop = 4'hF; req_eop = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_dat[i*64 +: 64] = 64'h100 + 64'(i);
      req_ctl[i*16 +: 16] = 16'hBEEF;
    end
    cyc();
    rst_n = 1'b1;
    pkt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_val && res_rdy) begin
        chk("t2_order", 64'(req_rdy), 64'(4'b0001 << (pkt % 4)));
        chk("t2_tag",   64'(res_ctl), 64'(16'hBEEC | 16'(pkt % 4)));
        chk("t2_dat",   res_dat, 64'h100 + 64'(pkt % 4));
        pkt++;
      end
      cyc();
    end
    chk("t2_pkts", 64'(pkt), 64'd16);
    chk("t2_cnt_full", 64'(out_cnt), 64'(12'b100_100_100_100));

    // 3: one response to req2 frees a credit, req2 is granted next
    rin_val = 1'b1; rin_sop = 1'b1; rin_eop = 1'b1; rin_ctl = 16'h0002; rin_dat = 64'h22;
    @(negedge clk);
    chk("t3_rsp_val", 64'(rsp_val), 64'h4);
    chk("t3_rsp_rdy", 64'(rin_rdy), 64'h1);
    cyc();
    rin_val = 1'b0;
    @(negedge clk);
    chk("t3_cnt2", 64'(out_cnt), 64'(12'b100_011_100_100));
    chk("t3_no_issue", 64'(res_val), 64'h0);
    cyc();
    @(negedge clk);
    chk("t3_grant2", 64'(req_rdy), 64'h4);
    chk("t3_tag2", 64'(res_ctl), 64'hBEEE);
    cyc();
    req_val = '0; req_sop = '0; req_eop = '0;
    @(negedge clk);
    chk("t3_cnt_full", 64'(out_cnt), 64'(12'b100_100_100_100));
    cyc();

    // 4: response to req1 held off for five cycles, then delivered
    rsp_rdy = 4'b1101;
    rin_val = 1'b1; rin_sop = 1'b1; rin_eop = 1'b1; rin_ctl = 16'h7771; rin_dat = 64'hDEAD;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_hold_rdy", 64'(rin_rdy), 64'h0);
      chk("t4_hold_val", 64'(rsp_val), 64'h2);
      cyc();
    end
    chk("t4_cnt_held", 64'(out_cnt), 64'(12'b100_100_100_100));
    rsp_rdy = 4'hF;
    @(negedge clk);
    chk("t4_rdy", 64'(rin_rdy), 64'h1);
    chk("t4_dat", rsp_dat, 64'hDEAD);
    chk("t4_ctl", 64'(rsp_ctl), 64'h7771);
    cyc();
    rin_val = 1'b0;
    @(negedge clk);
    chk("t4_cnt1", 64'(out_cnt), 64'(12'b100_100_011_100));

    // Same-cycle issue and return for req1 leaves the count alone
    cyc();
    req_val[1] = 1'b1; req_sop[1] = 1'b1; req_eop[1] = 1'b1;
    cyc();
    rin_val = 1'b1; rin_ctl = 16'h0001;
    @(negedge clk);
    chk("tx_issue", 64'(req_rdy), 64'h2);
    chk("tx_return", 64'(rsp_val), 64'h2);
    cyc();
    rin_val = 1'b0; req_val = '0; req_sop = '0; req_eop = '0;
    @(negedge clk);
    chk("tx_cnt1", 64'(out_cnt), 64'(12'b100_100_011_100));
    chk("tx_err", 64'(err), 64'h0);
    cyc();

    // 5: three-requester instance, bad tag and underflow
    rst3_n = 1'b1;
    rin_val3 = 1'b1; rin_eop3 = 1'b1; rin_ctl3 = 8'h3A; rin_dat3 = 8'h55; rsp_rdy3 = 3'b000;
    @(negedge clk);
    chk("t5_bad_val", 64'(rsp_val3), 64'h0);
    chk("t5_bad_rdy", 64'(rin_rdy3), 64'h1);
    chk("t5_err_pre", 64'(err3), 64'h0);
    cyc();
    rin_val3 = 1'b0;
    chk("t5_bad_err", 64'(err3), 64'h1);
    rst3_n = 1'b0;
    #1;
    chk("t5_rst_err", 64'(err3), 64'h0);
    cyc();
    rst3_n = 1'b1;
    rin_val3 = 1'b1; rin_ctl3 = 8'h0F; rsp_rdy3 = 3'b111;
    @(negedge clk);
    chk("t5_uf_val", 64'(rsp_val3), 64'h1);
    cyc();
    rin_val3 = 1'b0;
    chk("t5_uf_err", 64'(err3), 64'h1);
    chk("t5_uf_cnt", 64'(out_cnt3), 64'h0);

    // 6: reset mid-packet, then a fresh packet from req1
    req_val[1] = 1'b1; req_sop[1] = 1'b1; req_eop[1] = 1'b0; req_dat[127:64] = 64'hAA;
    cyc();
    @(negedge clk);
    chk("t6_busy", 64'(req_rdy), 64'h2);
    cyc();
    req_sop[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_res_val", 64'(res_val), 64'h0);
    chk("t6_rst_req_rdy", 64'(req_rdy), 64'h0);
    chk("t6_rst_cnt",     64'(out_cnt), 64'h0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_nonsop_ignored", 64'(res_val), 64'h0);
    cyc();
    req_sop[1] = 1'b1; req_eop[1] = 1'b1;
    @(negedge clk);
    chk("t6_idle", 64'(res_val), 64'h0);
    cyc();
    @(negedge clk);
    chk("t6_grant1", 64'(req_rdy), 64'h2);
    chk("t6_sop", 64'(res_sop), 64'h1);
    cyc();
    req_val = '0; req_sop = '0; req_eop = '0;
    @(negedge clk);
    chk("t6_cnt1", 64'(out_cnt), 64'h008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
